// File: rtl/main_pio_pkg.sv
// Shared constants for the Qsys PIO slaves: word addresses and edge-type encodings.
package main_pio_pkg;

   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/button_debouncer.sv
// One button bit: 2-flop synchroniser, polarity correction and a stable-level
// debounce counter. deb only follows the pin after it has held a new level for
// DEBOUNCE_CYCLES consecutive synchronised samples.
module button_debouncer
   import main_pio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic deb
);

   localparam logic             INACTIVE = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] TERM     = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1, sync2;
   logic             s;
   logic [CNT_W-1:0] cnt;

   // Synchroniser; resets to the released pin level so no fake press appears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= INACTIVE;
         sync2 <= INACTIVE;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
      end
   end

   assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

   // Count consecutive samples that disagree with deb; accept the level at terminal count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         deb <= 1'b0;
      end else if (s == deb) begin
         cnt <= '0;
      end else if (cnt == TERM) begin
         cnt <= '0;
         deb <= s;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/main_button_in_pio.sv
// Avalon-MM input PIO for the push-buttons: debounced DATA, IRQ mask,
// sticky RW1C edge capture and a registered level interrupt.
module main_button_in_pio
   import main_pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19,
   parameter int ACTIVE_LOW      = 1,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic             wr;
   logic [WIDTH-1:0] deb, deb_d;
   logic [WIDTH-1:0] irq_mask, edge_capture;
   logic [WIDTH-1:0] rise, fall, edge_set, cap_clr;
   logic             unused_wdata;

   assign wr           = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_deb
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_deb (
         .clk    (clk),
         .reset_n(reset_n),
         .pin    (in_port[i]),
         .deb    (deb[i])
      );
   end

   // Delayed copy of the debounced state for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) deb_d <= '0;
      else          deb_d <= deb;
   end

   assign rise    = deb & ~deb_d;
   assign fall    = ~deb & deb_d;
   assign cap_clr = (wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

   // Select which logical transitions are captured.
   always_comb begin
      edge_set = rise;
      if (EDGE_TYPE == EDGE_FALL)     edge_set = fall;
      else if (EDGE_TYPE == EDGE_ANY) edge_set = rise | fall;
   end

   // Mask/capture registers and interrupt; a new edge beats a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask     <= '0;
         edge_capture <= '0;
         irq          <= 1'b0;
      end else begin
         if (wr && address == PIO_ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
         edge_capture <= (edge_capture & ~cap_clr) | edge_set;
         irq          <= |(edge_capture & irq_mask);
      end
   end

   // Zero-wait-state read mux, zero when not selected.
   always_comb begin
      readdata = '0;
      if (chipselect) begin
         case (address)
            PIO_ADDR_DATA:    readdata = 32'(deb);
            PIO_ADDR_IRQMASK: readdata = 32'(irq_mask);
            PIO_ADDR_EDGECAP: readdata = 32'(edge_capture);
            default:          readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_main_button_in_pio.sv
// Bench for main_button_in_pio: directed scenarios with literal expectations,
// then randomised pins/bus traffic, all checked every cycle against a window-based model.
module tb_main_button_in_pio;

   localparam int W = 4;
   localparam int D = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic [W-1:0]  in_port = 4'hF;
   logic          irq;

   main_button_in_pio #(
      .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(4), .ACTIVE_LOW(1), .EDGE_TYPE(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // deb flips when the last D synchronised samples (pin seen 2 cycles earlier)
   // all disagree with it; an accepted rise shows in EDGECAP one cycle later.
   logic [W-1:0] m_deb, m_mask, m_cap, m_rose;
   logic         m_irq;
   logic [W-1:0] m_hist[$];

   task automatic model_reset();
      m_deb = '0; m_mask = '0; m_cap = '0; m_rose = '0; m_irq = 1'b0;
      m_hist.delete();
      repeat (D + 2) m_hist.push_back('0);
   endtask

   task automatic model_step();
      logic         wr;
      logic [W-1:0] clr, nd;
      logic         all_other;
      wr    = chipselect && !write_n;
      m_irq = |(m_cap & m_mask);
      clr   = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      m_cap = (m_cap & ~clr) | m_rose;
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
      m_hist.push_back(~in_port);
      while (m_hist.size() > D + 2) m_hist.pop_front();
      nd = m_deb;
      for (int b = 0; b < W; b++) begin
         all_other = 1'b1;
         for (int j = 0; j < D; j++)
            if (m_hist[j][b] == m_deb[b]) all_other = 1'b0;
         if (all_other) nd[b] = ~m_deb[b];
      end
      m_rose = nd & ~m_deb;
      m_deb  = nd;
   endtask

   function automatic logic [31:0] exp_rd();
      if (!chipselect) return '0;
      case (address)
         2'd0:    return 32'(m_deb);
         2'd2:    return 32'(m_mask);
         2'd3:    return 32'(m_cap);
         default: return '0;
      endcase
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else          model_step();
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("readdata", readdata, exp_rd());
         chk("irq", 32'(irq), 32'(m_irq));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      tick();
      write_n = 1'b1;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      chipselect = 1'b1; write_n = 1'b1; address = a;
      #1;
      chk(name, readdata, exp);
   endtask

   initial begin
      int idx;
      // 1: reset with all buttons released
      in_port = 4'hF; reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (20) tick();
      rd_chk("t1_data", 2'd0, 32'h0);
      rd_chk("t1_edgecap", 2'd3, 32'h0);
      chk("t1_irq", 32'(irq), 32'h0);

      // 2: press button 0, latency 10 cycles to DATA, 11 to EDGECAP
      in_port[0] = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 9) rd_chk("t2_data_c9", 2'd0, 32'h0);
      end
      rd_chk("t2_data_c10", 2'd0, 32'h1);
      rd_chk("t2_edgecap_c10", 2'd3, 32'h0);
      tick();
      rd_chk("t2_edgecap_c11", 2'd3, 32'h1);

      // 3: 5-cycle glitch on button 1 is rejected
      in_port[1] = 1'b0;
      repeat (5) tick();
      in_port[1] = 1'b1;
      repeat (15) tick();
      rd_chk("t3_data", 2'd0, 32'h1);
      rd_chk("t3_edgecap", 2'd3, 32'h1);

      // 4: mask then W1C clear
      bus_wr(2'd2, 32'h1);
      chk("t4_irq_same", 32'(irq), 32'h0);
      rd_chk("t4_mask", 2'd2, 32'h1);
      tick();
      chk("t4_irq_next", 32'(irq), 32'h1);
      bus_wr(2'd3, 32'h1);
      rd_chk("t4_edgecap_clr", 2'd3, 32'h0);
      chk("t4_irq_hold", 32'(irq), 32'h1);
      tick();
      chk("t4_irq_clr", 32'(irq), 32'h0);

      // 5: W1C of bit 2 in the same cycle as its capture
      in_port[2] = 1'b0;
      repeat (10) tick();
      bus_wr(2'd3, 32'h4);
      rd_chk("t5_edgecap_setwins", 2'd3, 32'h4);
      rd_chk("t5_data", 2'd0, 32'h5);
      chk("t5_irq", 32'(irq), 32'h0);
      bus_wr(2'd0, 32'hF);
      rd_chk("t5_data_ro", 2'd0, 32'h5);
      bus_wr(2'd3, 32'hF);

      // 6: reset while button 3 is mid-debounce, pins stay pressed
      in_port[3] = 1'b0;
      repeat (7) tick();
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) rd_chk("t6_data_c1", 2'd0, 32'h0);
         if (c == 9) rd_chk("t6_data_c9", 2'd0, 32'h0);
      end
      rd_chk("t6_data_c10", 2'd0, 32'hD);
      rd_chk("t6_mask_reset", 2'd2, 32'h0);
      tick();
      rd_chk("t6_edgecap", 2'd3, 32'hD);
      repeat (20) tick();
      rd_chk("t6_edgecap_nodup", 2'd3, 32'hD);
      bus_wr(2'd3, 32'hF);
      rd_chk("t6_edgecap_clr", 2'd3, 32'h0);

      // Random phase: slow pin changes plus random bus traffic, one mid-run reset
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) begin
            idx = int'($urandom_range(0, W - 1));
            in_port[idx] = ~in_port[idx];
         end
         chipselect = ($urandom_range(0, 3) != 0);
         write_n    = ($urandom_range(0, 3) != 0);
         address    = 2'($urandom);
         writedata  = $urandom;
         if (i == 1500) reset_n = 1'b0;
         if (i == 1502) reset_n = 1'b1;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
